// File: rtl/clk_count_sec.sv
// clk_count_sec: seconds stage of the digital clock.
// Divides CLK down to a one-second tick, counts seconds 0-59 and emits a
// one-cycle carry to the minutes stage. Also provides a half-second blink
// flag and a fast-advance divider used while setting the time.
// Build option: define SEC_BCD_EN to report secs as packed BCD (59 = 8'h59);
// otherwise secs is plain binary (59 = 8'd59).
module clk_count_sec #(
    parameter int TICK_DIV = 50_000_000,
    parameter int FAST_DIV = 1000
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       rst_counters,
    input  logic       run,
    input  logic       fast_adv,
    output logic [7:0] secs,
    output logic       sec_tick,
    output logic       count_up_min,
    output logic       blink
);

    localparam int          PW        = $clog2(TICK_DIV);
    localparam logic [31:0] TICK_TC   = 32'(TICK_DIV - 1);
    localparam logic [31:0] FAST_TC   = 32'(FAST_DIV - 1);
    localparam logic [31:0] TICK_HALF = 32'(TICK_DIV / 2);
    localparam logic [31:0] FAST_HALF = 32'(FAST_DIV / 2);

`ifdef SEC_BCD_EN
    localparam logic [7:0]  SECS_LAST = 8'h59;
`else
    localparam logic [7:0]  SECS_LAST = 8'd59;
`endif

    logic [PW-1:0] presc;
    logic [31:0]   presc_ext;
    logic [31:0]   div_tc;
    logic [31:0]   div_half;
    logic          term;
    logic [7:0]    secs_inc;

    assign presc_ext = 32'(presc);

    // Divider selection and terminal-count decode; >= lets a switch into fast
    // mode with the prescaler already beyond the fast terminal count still
    // tick on the next running cycle.
    always_comb begin
        div_tc   = fast_adv ? FAST_TC : TICK_TC;
        div_half = fast_adv ? FAST_HALF : TICK_HALF;
        term     = run && (presc_ext >= div_tc);
    end

    // Next seconds value when a tick lands and secs is not at its last value.
    always_comb begin
        secs_inc = secs + 8'd1;
`ifdef SEC_BCD_EN
        if (secs[3:0] == 4'd9) begin
            secs_inc = {secs[7:4] + 4'd1, 4'd0};
        end else begin
            secs_inc = {secs[7:4], secs[3:0] + 4'd1};
        end
`endif
    end

    // Prescaler and seconds counter: clear, hold, tick or advance.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            secs  <= 8'd0;
        end else if (rst_counters) begin
            presc <= '0;
            secs  <= 8'd0;
        end else if (run) begin
            if (term) begin
                presc <= '0;
                secs  <= (secs == SECS_LAST) ? 8'd0 : secs_inc;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Combinational pulses; a synchronous clear suppresses the tick and carry.
    always_comb begin
        sec_tick     = term && !rst_counters;
        count_up_min = sec_tick && (secs == SECS_LAST);
        blink        = presc_ext < div_half;
    end

endmodule

// File: tb/tb_clk_count_sec.sv
// Testbench for clk_count_sec with TICK_DIV=10, FAST_DIV=2.
// Directed scenarios followed by a randomized run, all checked against an
// integer model of elapsed prescaler counts and seconds.
module tb_clk_count_sec;

    localparam int TICK_DIV = 10;
    localparam int FAST_DIV = 2;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       rst_counters;
    logic       run;
    logic       fast_adv;
    logic [7:0] secs;
    logic       sec_tick;
    logic       count_up_min;
    logic       blink;

    int checks = 0;
    int errors = 0;

    int m_presc = 0;
    int m_sec   = 0;
    bit last_tick;

    clk_count_sec #(.TICK_DIV(TICK_DIV), .FAST_DIV(FAST_DIV)) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .rst_counters (rst_counters),
        .run          (run),
        .fast_adv     (fast_adv),
        .secs         (secs),
        .sec_tick     (sec_tick),
        .count_up_min (count_up_min),
        .blink        (blink)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] enc(input int s);
`ifdef SEC_BCD_EN
        return 8'(((s / 10) << 4) | (s % 10));
`else
        return 8'(s);
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge against the model, then advance
    // the model at the posedge. Inputs change 1 time unit after the posedge.
    task automatic cycle();
        int d;
        bit exp_tick;
        @(negedge CLK);
        d = fast_adv ? FAST_DIV : TICK_DIV;
        exp_tick = run && (m_presc >= d - 1) && !rst_counters;
        chk("secs", secs, enc(m_sec));
        chk("sec_tick", {7'd0, sec_tick}, {7'd0, exp_tick});
        chk("count_up_min", {7'd0, count_up_min}, {7'd0, exp_tick && (m_sec == 59)});
        chk("blink", {7'd0, blink}, {7'd0, (m_presc < d / 2)});
        last_tick = sec_tick;
        @(posedge CLK);
        if (rst_counters) begin
            m_presc = 0;
            m_sec   = 0;
        end else if (run) begin
            if (m_presc >= d - 1) begin
                m_presc = 0;
                m_sec   = (m_sec + 1) % 60;
            end else begin
                m_presc++;
            end
        end
        #1;
    endtask

    initial begin
        int ticks;
        int first_tick;
        int second_tick;
        int n;
        int held_sec;

        rst_n = 1'b0;
        rst_counters = 1'b0;
        run = 1'b0;
        fast_adv = 1'b0;
        #3;
        chk("reset_secs", secs, 8'd0);
        chk("reset_tick", {7'd0, sec_tick}, 8'd0);
        chk("reset_cum", {7'd0, count_up_min}, 8'd0);
        chk("reset_blink", {7'd0, blink}, 8'd1);
        #20;
        rst_n = 1'b1;
        @(posedge CLK);
        #1;

        // Scenario 1: 25 running cycles from a cleared state.
        run = 1'b1;
        ticks = 0;
        first_tick = 0;
        second_tick = 0;
        for (int i = 1; i <= 25; i++) begin
            cycle();
            if (last_tick) begin
                ticks++;
                if (ticks == 1) first_tick = i;
                if (ticks == 2) second_tick = i;
            end
        end
        chk("s1_tick_count", 8'(ticks), 8'd2);
        chk("s1_first_tick", 8'(first_tick), 8'd10);
        chk("s1_second_tick", 8'(second_tick), 8'd20);
        chk("s1_secs", secs, enc(2));

        // Scenario 2: run to 59 and wrap.
        n = 0;
        while (!(m_sec == 59 && m_presc == TICK_DIV - 1) && n < 800) begin
            cycle();
            n++;
        end
        chk("s2_reach59", 8'(n < 800), 8'd1);
        chk("s2_secs59", secs, enc(59));
        cycle();
        chk("s2_carry_seen", {7'd0, last_tick}, 8'd1);
        chk("s2_wrap", secs, 8'd0);
        cycle();
        chk("s2_no_tick_after", {7'd0, last_tick}, 8'd0);

        // Scenario 3: pause at presc 6 for 7 cycles, then resume.
        n = 0;
        while (m_presc != 6 && n < 20) begin
            cycle();
            n++;
        end
        held_sec = m_sec;
        run = 1'b0;
        for (int i = 0; i < 7; i++) cycle();
        chk("s3_hold_secs", secs, enc(held_sec));
        run = 1'b1;
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            if (last_tick && n == 0) n = i;
        end
        chk("s3_resume_latency", 8'(n), 8'd4);

        // Scenario 4: switch to fast mode with presc at 7.
        n = 0;
        while (m_presc != 7 && n < 20) begin
            cycle();
            n++;
        end
        fast_adv = 1'b1;
        cycle();
        chk("s4_immediate_tick", {7'd0, last_tick}, 8'd1);
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (last_tick) ticks++;
        end
        chk("s4_fast_ticks", 8'(ticks), 8'd4);
        fast_adv = 1'b0;

        // Scenario 5: rst_counters coincides with the 59 -> 0 carry.
        n = 0;
        while (!(m_sec == 59 && m_presc == TICK_DIV - 1) && n < 800) begin
            cycle();
            n++;
        end
        rst_counters = 1'b1;
        cycle();
        chk("s5_no_tick", {7'd0, last_tick}, 8'd0);
        rst_counters = 1'b0;
        chk("s5_secs", secs, 8'd0);
        chk("s5_blink", {7'd0, blink}, 8'd1);
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            if (last_tick && n == 0) n = i;
        end
        chk("s5_restart_tick", 8'(n), 8'd10);

        // Scenario 6: async reset mid-second at secs 33.
        n = 0;
        while (!(m_sec == 33 && m_presc == 5) && n < 800) begin
            cycle();
            n++;
        end
        chk("s6_secs33", secs, enc(33));
        run = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_async_secs", secs, 8'd0);
        chk("s6_async_blink", {7'd0, blink}, 8'd1);
        chk("s6_async_tick", {7'd0, sec_tick}, 8'd0);
        m_presc = 0;
        m_sec = 0;
        #10;
        rst_n = 1'b1;
        @(posedge CLK);
        #1;
        run = 1'b1;
        n = 0;
        for (int i = 1; i <= 15; i++) begin
            cycle();
            if (last_tick && n == 0) n = i;
        end
        chk("s6_restart_tick", 8'(n), 8'd10);
        chk("s6_restart_secs", secs, enc(1));

        // Randomized run.
        for (int i = 0; i < 3000; i++) begin
            run = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) fast_adv = ~fast_adv;
            rst_counters = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst_counters = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
